// File: rtl/booth_radix4_iter_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_radix4_iter_mult_if                                            |
// | Operand/result valid-ready bus for the iterative Booth multiplier.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface booth_radix4_iter_mult_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] result;

  modport master (
    output in_valid, x, y, signed_mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, x, y, signed_mode, out_ready,
    output in_ready, out_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/booth_radix4_iter_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_radix4_iter_mult                                               |
// | Iterative radix-4 Booth multiplier, one group per clock, optional    |
// | low-group truncation; macro BOOTH_APPROX_COMP_EN adds bias offset.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module booth_radix4_iter_mult #(
  parameter int N             = 16,
  parameter int APPROX_GROUPS = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  booth_radix4_iter_mult_if.slave bus
);

  localparam int c_GROUPS = N / 2 + 1;
  localparam int c_GW     = $clog2(c_GROUPS);
  localparam int c_ACC_W  = 2 * N + 2;
  localparam int c_XE_W   = N + 3;
  localparam int c_PP_W   = N + 3;

  localparam logic [c_GW-1:0] c_LAST   = c_GW'(c_GROUPS - 1);
  localparam logic [c_GW-1:0] c_APPROX = c_GW'(APPROX_GROUPS);

`ifdef BOOTH_APPROX_COMP_EN
  localparam int c_COMP_SH = (APPROX_GROUPS > 0) ? (2 * APPROX_GROUPS - 1) : 0;
  localparam logic [c_ACC_W-1:0] c_ACC_INIT =
      (APPROX_GROUPS > 0) ? ({{(c_ACC_W-1){1'b0}}, 1'b1} << c_COMP_SH) : '0;
`else
  localparam logic [c_ACC_W-1:0] c_ACC_INIT = '0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       x_q, x_d;
  logic [N-1:0]       y_q, y_d;
  logic               sm_q, sm_d;
  logic [c_ACC_W-1:0] acc_q, acc_d;
  logic [c_GW-1:0]    g_q, g_d;
  logic [2*N-1:0]     result_q, result_d;

  logic               w_in_ready;
  logic               w_out_valid;
  logic [c_XE_W-1:0]  w_xe;
  logic [N+1:0]       w_ye;
  logic [2:0]         w_grp;
  logic [c_PP_W-1:0]  w_mag;
  logic               w_neg;
  logic               w_trunc;
  logic [c_ACC_W-1:0] w_pp;
  logic [c_ACC_W-1:0] w_acc_sum;

  // Extended multiplier carries an implicit 0 below bit 0, so group g sits at [2g+2:2g].
  assign w_xe  = {{2{sm_q & x_q[N-1]}}, x_q, 1'b0};
  assign w_ye  = {{2{sm_q & y_q[N-1]}}, y_q};
  assign w_grp = w_xe[{g_q, 1'b0} +: 3];

  generate
    if (APPROX_GROUPS > 0) begin : g_trunc
      assign w_trunc = (g_q < c_APPROX);
    end else begin : g_exact
      assign w_trunc = 1'b0;
    end
  endgenerate

  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    case (w_grp)
      3'b001, 3'b010: w_mag = {w_ye[N+1], w_ye};
      3'b011:         w_mag = {w_ye, 1'b0};
      3'b100: begin
        w_mag = {w_ye, 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_mag = {w_ye[N+1], w_ye};
        w_neg = 1'b1;
      end
      default: ;
    endcase
    if (w_trunc) begin
      w_mag = '0;
      w_neg = 1'b0;
    end
  end

  // Negative rows are inverted here and completed by the carry-in on the adder.
  assign w_pp      = {{(c_ACC_W-c_PP_W){w_mag[c_PP_W-1]}}, w_mag} << {g_q, 1'b0};
  assign w_acc_sum = acc_q + (w_neg ? ~w_pp : w_pp) + {{(c_ACC_W-1){1'b0}}, w_neg};

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sm_d        = sm_q;
    acc_d       = acc_q;
    g_d         = g_q;
    result_d    = result_q;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          x_d     = bus.x;
          y_d     = bus.y;
          sm_d    = bus.signed_mode;
          acc_d   = c_ACC_INIT;
          g_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = w_acc_sum;
        if (g_q == c_LAST) begin
          result_d = w_acc_sum[2*N-1:0];
          g_d      = '0;
          state_d  = DONE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sm_q     <= 1'b0;
      acc_q    <= '0;
      g_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sm_q     <= sm_d;
      acc_q    <= acc_d;
      g_q      <= g_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_iter_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_booth_radix4_iter_mult                                            |
// | Scoreboard bench: directed vectors, backpressure, mid-op reset.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_booth_radix4_iter_mult;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  booth_radix4_iter_mult_if #(.N(16)) b16 ();
  booth_radix4_iter_mult_if #(.N(16)) bap ();
  booth_radix4_iter_mult_if #(.N(8))  b8  ();

  booth_radix4_iter_mult #(.N(16), .APPROX_GROUPS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave));
  booth_radix4_iter_mult #(.N(16), .APPROX_GROUPS(2)) u_apx (
    .clk(clk), .rst_n(rst_n), .bus(bap.slave));
  booth_radix4_iter_mult #(.N(8), .APPROX_GROUPS(0)) u_n8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave));

  logic [31:0] q16[$];
  logic [31:0] qap[$];
  logic [15:0] q8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // Output monitors: pop and compare on every output handshake
  logic prev_ov16 = 1'b0;
  int   rise_cyc  = -1;
  always @(negedge clk) begin
    if (b16.out_valid && !prev_ov16) rise_cyc = cyc;
    prev_ov16 = b16.out_valid;
    if (rst_n && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) fail_event("res16_unexpected");
      else chk("res16", 64'(b16.result), 64'(q16.pop_front()));
    end
    if (rst_n && bap.out_valid && bap.out_ready) begin
      if (qap.size() == 0) fail_event("resap_unexpected");
      else chk("res_approx", 64'(bap.result), 64'(qap.pop_front()));
    end
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) fail_event("res8_unexpected");
      else chk("res8", 64'(b8.result), 64'(q8.pop_front()));
    end
  end

  bit rnd_or = 1'b0;
  always @(posedge clk) begin
    if (rnd_or) begin
      #1;
      b16.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  int hs_cyc = 0;

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send16(input logic [15:0] xv, input logic [15:0] yv, input logic sm,
                        input logic [31:0] ex, input bit push);
    bit ok;
    ok = 1'b0;
    b16.x = xv; b16.y = yv; b16.signed_mode = sm; b16.in_valid = 1'b1;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = b16.in_ready;
    end
    if (!ok) fail_event("hs16_timeout");
    else begin
      hs_cyc = cyc;
      if (push) q16.push_back(ex);
    end
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    b16.x = 16'($urandom); b16.y = 16'($urandom); b16.signed_mode = 1'($urandom);
  endtask

  task automatic send8(input logic [7:0] xv, input logic [7:0] yv, input logic sm,
                       input logic [15:0] ex);
    bit ok;
    ok = 1'b0;
    b8.x = xv; b8.y = yv; b8.signed_mode = sm; b8.in_valid = 1'b1;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = b8.in_ready;
    end
    if (!ok) fail_event("hs8_timeout");
    else q8.push_back(ex);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    b8.x = 8'($urandom); b8.y = 8'($urandom);
  endtask

  task automatic drain16();
    for (int i = 0; i < 400 && q16.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q16.size() != 0) begin
      fail_event("drain16_timeout");
      q16.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] xv, yv;
  logic [7:0]  xv8, yv8;
  logic        sm;
  logic [31:0] ex;
  logic [15:0] ex8;
  int          sx, sy;
  bit          ok;

  initial begin
    b16.in_valid = 1'b0; b16.x = '0; b16.y = '0; b16.signed_mode = 1'b0; b16.out_ready = 1'b0;
    bap.in_valid = 1'b0; bap.x = '0; bap.y = '0; bap.signed_mode = 1'b0; bap.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.x  = '0; b8.y  = '0; b8.signed_mode  = 1'b0; b8.out_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(b16.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("rst_result", 64'(b16.result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Max unsigned operands, plus latency and single-cycle out_valid
    b16.out_ready = 1'b1;
    send16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
    drain16();
    chk("latency", 64'(rise_cyc - hs_cyc), 64'd10);
    chk("ov_pulse", 64'(b16.out_valid), 64'd0);
    chk("in_ready_after", 64'(b16.in_ready), 64'd1);

    send16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
    drain16();
    send16(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b1);
    drain16();
    send16(16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1, 1'b1);
    drain16();
    send16(16'h0013, 16'h0010, 1'b0, 32'h00000130, 1'b1);
    drain16();

    // Truncated low groups on the approximate instance
    bap.x = 16'h0013; bap.y = 16'h0010; bap.signed_mode = 1'b0; bap.in_valid = 1'b1;
    @(negedge clk);
    chk("apx_in_ready", 64'(bap.in_ready), 64'd1);
`ifdef BOOTH_APPROX_COMP_EN
    qap.push_back(32'h00000108);
`else
    qap.push_back(32'h00000100);
`endif
    @(posedge clk); #1;
    bap.in_valid = 1'b0;
    for (int i = 0; i < 40 && qap.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (qap.size() != 0) begin
      fail_event("apx_timeout");
      qap.delete();
    end

    // Backpressure: result held, new operands refused until drained
    b16.out_ready = 1'b0;
    send16(16'h0003, 16'h0004, 1'b0, 32'd12, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = b16.out_valid;
    end
    if (!ok) fail_event("bp_out_valid_timeout");
    b16.x = 16'd5; b16.y = 16'd6; b16.signed_mode = 1'b0; b16.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(b16.out_valid), 64'd1);
      chk("bp_in_ready", 64'(b16.in_ready), 64'd0);
      chk("bp_result", 64'(b16.result), 64'd12);
    end
    @(posedge clk); #1;
    b16.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_next", 64'(b16.in_ready), 64'd1);
    q16.push_back(32'd30);
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    drain16();

    // Asynchronous reset in the 4th CALC cycle
    send16(16'h1234, 16'h5678, 1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("mid_rst_result", 64'(b16.result), 64'd0);
    chk("mid_rst_in_ready", 64'(b16.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send16(16'd7, 16'd9, 1'b0, 32'd63, 1'b1);
    drain16();

    // Random operands with random gaps and random out_ready
    rnd_or = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      xv = 16'($urandom); yv = 16'($urandom); sm = 1'($urandom);
      if (sm) begin
        sx = int'($signed(xv)); sy = int'($signed(yv));
        ex = 32'(sx * sy);
      end else begin
        ex = {16'd0, xv} * {16'd0, yv};
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send16(xv, yv, sm, ex, 1'b1);
    end
    drain16();
    rnd_or = 1'b0;
    @(posedge clk); #1;
    b16.out_ready = 1'b1;

    // Random sweep on the 8-bit instance
    for (int i = 0; i < 300; i++) begin
      xv8 = 8'($urandom); yv8 = 8'($urandom); sm = 1'($urandom);
      if (sm) begin
        sx = int'($signed(xv8)); sy = int'($signed(yv8));
        ex8 = 16'(sx * sy);
      end else begin
        ex8 = {8'd0, xv8} * {8'd0, yv8};
      end
      send8(xv8, yv8, sm, ex8);
    end
    for (int i = 0; i < 40 && q8.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q8.size() != 0) begin
      fail_event("drain8_timeout");
      q8.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
